// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - sticky/maskable interrupt status and event counters for two timer done lines
// Register file is reached over a minimal single-outstanding AXI4-Lite slave.
module timer_irq_ctrl #(
  parameter int AXI_ADDR_BW_p = 12,
  parameter int EVT_CNT_BW_p  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cnt0_done,
  input  logic                     i_cnt1_done,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  input  logic                     i_axi_wvalid,
  input  logic                     i_axi_bready,
  input  logic [31:0]              i_axi_wdata,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  input  logic                     i_axi_rready,
  output logic                     o_axi_awready,
  output logic                     o_axi_wready,
  output logic                     o_axi_bvalid,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_arready,
  output logic                     o_axi_rvalid,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_irq
);

  localparam logic [EVT_CNT_BW_p-1:0] CNT_MAX = '1;

  logic [1:0]              prev_done;
  logic [1:0]              evt;
  logic [1:0]              status;
  logic [1:0]              enable;
  logic [1:0]              status_clr;
  logic [EVT_CNT_BW_p-1:0] cnt0;
  logic [EVT_CNT_BW_p-1:0] cnt1;
  logic [EVT_CNT_BW_p-1:0] cnt0_next;
  logic [EVT_CNT_BW_p-1:0] cnt1_next;
  logic                    wr_fire;
  logic                    rd_fire;
  logic [2:0]              wr_sel;
  logic [2:0]              rd_sel;
  logic [31:0]             rd_word;
  logic                    unused_bits;

  assign evt     = {i_cnt1_done, i_cnt0_done} & ~prev_done;
  assign wr_fire = o_axi_awready & i_axi_awvalid & i_axi_wvalid;
  assign rd_fire = o_axi_arready & i_axi_arvalid;
  assign wr_sel  = i_axi_awaddr[4:2];
  assign rd_sel  = i_axi_araddr[4:2];

  assign unused_bits = ^{i_axi_awaddr, i_axi_araddr, i_axi_wdata};

  // A clear and an event on the same edge leave the count at 1, and set beats W1C.
  function automatic logic [EVT_CNT_BW_p-1:0] step_cnt(
    input logic [EVT_CNT_BW_p-1:0] cur,
    input logic                    clr,
    input logic                    ev
  );
    logic [EVT_CNT_BW_p-1:0] r;
    r = clr ? '0 : cur;
    if (ev && r != CNT_MAX) r = r + EVT_CNT_BW_p'(1);
    return r;
  endfunction

  always_comb begin
    status_clr = (wr_fire && wr_sel == 3'd0) ? i_axi_wdata[1:0] : 2'b00;
    cnt0_next  = step_cnt(cnt0, wr_fire && wr_sel == 3'd3, evt[0]);
    cnt1_next  = step_cnt(cnt1, wr_fire && wr_sel == 3'd4, evt[1]);
  end

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      3'd0:    rd_word[1:0] = status;
      3'd1:    rd_word[1:0] = enable;
      3'd2:    rd_word[1:0] = status & enable;
      3'd3:    rd_word[EVT_CNT_BW_p-1:0] = cnt0;
      3'd4:    rd_word[EVT_CNT_BW_p-1:0] = cnt1;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_done     <= '0;
      status        <= '0;
      enable        <= '0;
      cnt0          <= '0;
      cnt1          <= '0;
      o_irq         <= 1'b0;
      o_axi_awready <= 1'b0;
      o_axi_wready  <= 1'b0;
      o_axi_bvalid  <= 1'b0;
      o_axi_bresp   <= 2'b00;
      o_axi_arready <= 1'b0;
      o_axi_rvalid  <= 1'b0;
      o_axi_rdata   <= '0;
      o_axi_rresp   <= 2'b00;
    end else begin
      prev_done <= {i_cnt1_done, i_cnt0_done};
      status    <= (status & ~status_clr) | evt;
      cnt0      <= cnt0_next;
      cnt1      <= cnt1_next;
      o_irq     <= |(status & enable);
      if (wr_fire && wr_sel == 3'd1) enable <= i_axi_wdata[1:0];

      // Write channel: one-cycle ready pulse, then hold the response until taken.
      o_axi_awready <= i_axi_awvalid & i_axi_wvalid & ~o_axi_bvalid & ~o_axi_awready;
      o_axi_wready  <= i_axi_awvalid & i_axi_wvalid & ~o_axi_bvalid & ~o_axi_awready;
      if (wr_fire) begin
        o_axi_bvalid <= 1'b1;
        o_axi_bresp  <= (wr_sel > 3'd4) ? 2'b10 : 2'b00;
      end else if (o_axi_bvalid && i_axi_bready) begin
        o_axi_bvalid <= 1'b0;
      end

      o_axi_arready <= i_axi_arvalid & ~o_axi_rvalid & ~o_axi_arready;
      if (rd_fire) begin
        o_axi_rvalid <= 1'b1;
        o_axi_rdata  <= rd_word;
        o_axi_rresp  <= (rd_sel > 3'd4) ? 2'b10 : 2'b00;
      end else if (o_axi_rvalid && i_axi_rready) begin
        o_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - directed bench with a register-level reference model for timer_irq_ctrl
module tb_timer_irq_ctrl;
  localparam int CNT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt0_done = 1'b0, cnt1_done = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_cmp = 0, n_err = 0;

  // Reference model state and its request strobes from the stimulus tasks
  int   m_status, m_enable, m_cnt0, m_cnt1, m_rdata, m_rresp;
  logic [1:0] m_prev;
  logic m_irq;
  logic mw_req = 1'b0, mr_req = 1'b0;
  int   mw_addr = 0, mw_data = 0, mr_addr = 0;

  timer_irq_ctrl #(.AXI_ADDR_BW_p(12), .EVT_CNT_BW_p(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cnt0_done(cnt0_done), .i_cnt1_done(cnt1_done),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .i_axi_wvalid(wvalid),
    .i_axi_bready(bready), .i_axi_wdata(wdata),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .i_axi_rready(rready),
    .o_axi_awready(awready), .o_axi_wready(wready), .o_axi_bvalid(bvalid),
    .o_axi_bresp(bresp), .o_axi_arready(arready), .o_axi_rvalid(rvalid),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mread(input int a);
    case ((a >> 2) & 7)
      0: return m_status;
      1: return m_enable;
      2: return m_status & m_enable;
      3: return m_cnt0;
      4: return m_cnt1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int st, en, c0, c1;
    logic [1:0] ev;
    if (!rst_n) begin
      m_status <= 0; m_enable <= 0; m_cnt0 <= 0; m_cnt1 <= 0;
      m_prev <= 2'b00; m_irq <= 1'b0; m_rdata <= 0; m_rresp <= 0;
    end else begin
      st = m_status; en = m_enable; c0 = m_cnt0; c1 = m_cnt1;
      ev = {cnt1_done, cnt0_done} & ~m_prev;
      if (mr_req) begin
        m_rdata <= mread(mr_addr);
        m_rresp <= (((mr_addr >> 2) & 7) > 4) ? 2 : 0;
      end
      m_irq <= ((st & en) != 0);
      if (mw_req) begin
        case ((mw_addr >> 2) & 7)
          0: st = st & ~(mw_data & 3);
          1: en = mw_data & 3;
          3: c0 = 0;
          4: c1 = 0;
          default: ;
        endcase
      end
      if (ev[0]) begin st = st | 1; if (c0 < CNT_MAX) c0++; end
      if (ev[1]) begin st = st | 2; if (c1 < CNT_MAX) c1++; end
      m_status <= st; m_enable <= en; m_cnt0 <= c0; m_cnt1 <= c1;
      m_prev <= {cnt1_done, cnt0_done};
    end
  end

  always @(negedge clk) chk("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});

  task automatic axi_write(input int a, input int d, input logic [1:0] exp_resp, input bit ev0);
    awaddr = a[11:0]; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk("awready", {31'b0, awready}, 32'd1);
    chk("wready", {31'b0, wready}, 32'd1);
    mw_req = 1'b1; mw_addr = a; mw_data = d;
    if (ev0) cnt0_done = 1'b1;
    @(negedge clk);
    mw_req = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (ev0) cnt0_done = 1'b0;
    chk("bvalid_set", {31'b0, bvalid}, 32'd1);
    chk("bresp", {30'b0, bresp}, {30'b0, exp_resp});
    chk("awready_drop", {31'b0, awready}, 32'd0);
    @(negedge clk);
    chk("bvalid_clr", {31'b0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input int a, input int exp_d, input logic [1:0] exp_resp, input int hold);
    araddr = a[11:0]; arvalid = 1'b1; rready = (hold == 0);
    @(negedge clk);
    chk("arready", {31'b0, arready}, 32'd1);
    mr_req = 1'b1; mr_addr = a;
    @(negedge clk);
    mr_req = 1'b0; arvalid = 1'b0;
    chk("rvalid_set", {31'b0, rvalid}, 32'd1);
    chk("rdata_lit", rdata, exp_d);
    chk("rresp_lit", {30'b0, rresp}, {30'b0, exp_resp});
    chk("model_rdata_lit", m_rdata, exp_d);
    chk("rdata_vs_model", rdata, m_rdata);
    chk("rresp_vs_model", {30'b0, rresp}, m_rresp);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("rvalid_hold", {31'b0, rvalid}, 32'd1);
        chk("rdata_hold", rdata, exp_d);
      end
      rready = 1'b1;
    end
    @(negedge clk);
    chk("rvalid_clr", {31'b0, rvalid}, 32'd0);
    rready = 1'b0;
  endtask

  task automatic chk_all_zero();
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_wready", {31'b0, wready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_bresp", {30'b0, bresp}, 32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", {30'b0, rresp}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero();
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a <= 16; a += 4) axi_read(a, 0, 2'b00, 0);
    axi_read(32'h14, 0, 2'b10, 0);
    axi_write(32'h18, 32'h3, 2'b10, 1'b0);
    axi_read(32'h04, 0, 2'b00, 0);

    // Single pulse on cnt0 with its enable set: irq two edges later
    axi_write(32'h04, 32'h1, 2'b00, 1'b0);
    cnt0_done = 1'b1;
    @(negedge clk);
    chk("irq_after_1", {31'b0, irq}, 32'd0);
    cnt0_done = 1'b0;
    @(negedge clk);
    chk("irq_after_2", {31'b0, irq}, 32'd1);
    axi_read(32'h00, 1, 2'b00, 0);
    axi_read(32'h08, 1, 2'b00, 0);
    axi_read(32'h0C, 1, 2'b00, 0);
    axi_write(32'h08, 32'h0, 2'b00, 1'b0);
    axi_read(32'h00, 1, 2'b00, 0);
    axi_write(32'h00, 32'h1, 2'b00, 1'b0);
    chk("irq_w1c", {31'b0, irq}, 32'd0);
    axi_read(32'h00, 0, 2'b00, 0);

    // Held-high done gives one event; masked until enabled
    axi_write(32'h04, 32'h0, 2'b00, 1'b0);
    cnt1_done = 1'b1;
    repeat (10) @(negedge clk);
    cnt1_done = 1'b0;
    axi_read(32'h10, 1, 2'b00, 0);
    axi_read(32'h00, 2, 2'b00, 0);
    chk("irq_masked", {31'b0, irq}, 32'd0);
    axi_write(32'h04, 32'h2, 2'b00, 1'b0);
    chk("irq_enabled", {31'b0, irq}, 32'd1);
    axi_write(32'h00, 32'h2, 2'b00, 1'b0);
    axi_write(32'h04, 32'h1, 2'b00, 1'b0);

    // Same-edge set vs W1C, and same-edge event vs counter clear
    axi_write(32'h00, 32'h1, 2'b00, 1'b1);
    axi_read(32'h00, 1, 2'b00, 0);
    axi_read(32'h0C, 2, 2'b00, 0);
    axi_write(32'h0C, 32'h0, 2'b00, 1'b1);
    axi_read(32'h0C, 1, 2'b00, 0);
    axi_write(32'h00, 32'h3, 2'b00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      cnt0_done = 1'b1; @(negedge clk);
      cnt0_done = 1'b0; @(negedge clk);
    end
    axi_read(32'h0C, 15, 2'b00, 0);
    axi_write(32'h00, 32'h3, 2'b00, 1'b0);

    awaddr = 12'h004; wdata = 32'h3; awvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("aw_only_awready", {31'b0, awready}, 32'd0);
      chk("aw_only_wready", {31'b0, wready}, 32'd0);
    end
    awvalid = 1'b0;

    axi_read(32'h0C, 15, 2'b00, 6);

    // Read of ENABLE on the same edge as its write sees the old value
    fork
      axi_write(32'h04, 32'h2, 2'b00, 1'b0);
      axi_read(32'h04, 1, 2'b00, 0);
    join
    axi_read(32'h04, 2, 2'b00, 0);

    // Stalled response, second write held off, then reset mid-transaction
    awaddr = 12'h004; wdata = 32'h3; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("stall_awready", {31'b0, awready}, 32'd1);
    mw_req = 1'b1; mw_addr = 4; mw_data = 3;
    @(negedge clk);
    mw_req = 1'b0;
    awaddr = 12'h00C; wdata = 32'h0;
    repeat (8) begin
      @(negedge clk);
      chk("stall_bvalid", {31'b0, bvalid}, 32'd1);
      chk("stall_awready2", {31'b0, awready}, 32'd0);
    end
    rst_n = 1'b0; cnt1_done = 1'b1;
    @(negedge clk);
    chk_all_zero();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(32'h10, 1, 2'b00, 0);
    axi_read(32'h00, 2, 2'b00, 0);
    axi_read(32'h04, 0, 2'b00, 0);
    cnt1_done = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Interrupt controller placed directly downstream of the AXI4-Lite timer/counter block. It consumes the two counter-done outputs and turns rising edges on them into sticky, maskable interrupt status bits. It also keeps per-channel saturating event counters and drives a single level interrupt line to the CPU. The register file is reached over its own AXI4-Lite slave port.

## Interface
- AXI_ADDR_BW_p, 12, AXI address width; bits [4:2] decode the register, other bits ignored
- EVT_CNT_BW_p, 16, width of each event counter (1..32)
- clk  input  1  single clock for all logic
- rst_n  input  1  reset, synchronous, active-low
- i_cnt0_done  input  1  done output of timer/counter 0
- i_cnt1_done  input  1  done output of timer/counter 1
- i_axi_awaddr  input  AXI_ADDR_BW_p  write address
- i_axi_awvalid, i_axi_wvalid, i_axi_bready  input  1  write handshakes
- i_axi_wdata  input  32  write data (no strobes; full-word writes)
- i_axi_araddr  input  AXI_ADDR_BW_p  read address
- i_axi_arvalid, i_axi_rready  input  1  read handshakes
- o_axi_awready, o_axi_wready, o_axi_bvalid  output  1  write handshakes
- o_axi_bresp  output  2  write response
- o_axi_arready, o_axi_rvalid  output  1  read handshakes
- o_axi_rdata  output  32  read data
- o_axi_rresp  output  2  read response
- o_irq  output  1  level interrupt, active-high

## Operation
- Edge detect: prev_doneN is registered each cycle. evtN = i_cntN_done & ~prev_doneN, one pulse per rising edge. A held-high done produces exactly one event.
- Register map (offset):
  - 0x00 STATUS: bits [1:0] sticky; set by evt1/evt0. Write 1 clears the bit, write 0 leaves it unchanged.
  - 0x04 ENABLE: bits [1:0], read/write.
  - 0x08 PENDING: STATUS & ENABLE, read-only. Writes are ignored and return OKAY.
  - 0x0C EVT_CNT0: counts evt0, saturating at all-ones. Any write clears it.
  - 0x10 EVT_CNT1: same behaviour for evt1.
  - Unused bits read 0.
- Unmapped offsets (0x14..0x1C): writes are dropped, reads return 0, response SLVERR (2'b10). Mapped offsets respond OKAY (2'b00).
- Simultaneous event and clear on the same cycle:
  - STATUS: set wins; the bit stays 1.
  - EVT_CNT: result is 1.
- Saturation: a counter at max stays at max on a further event.
- o_irq = registered |(STATUS & ENABLE); it follows the state one cycle later.

## Timing
- Reset (rst_n low at a clk edge) drives every output to 0, including o_axi_rdata and both resp fields. It also clears STATUS, ENABLE, both EVT_CNT and prev_done.
  - Reset mid-transaction aborts it. There is no bvalid or rvalid afterwards.
  - A done input already high when reset releases counts as an event on the first cycle out of reset, because prev_done=0.
- Write channel: when awvalid & wvalid & ~bvalid & ~awready are all high at an edge, awready and wready go high together for exactly one cycle. The handshake completes on the following edge.
  - The register update happens at that handshake edge.
  - bvalid rises the next cycle, together with bresp, and is held until bready is sampled high. The next write is not accepted until bvalid drops.
  - An aw-only or w-only request waits; no ready is asserted.
- Read channel: when arvalid & ~rvalid & ~arready are high at an edge, arready pulses for one cycle.
  - At the handshake edge, rdata and rresp are captured and rvalid rises. Both are held stable until rready.
  - Read data reflects register state before any write completing on the same edge.
- Read and write channels are independent and may complete on the same edge.
- Event-to-STATUS latency: done rises at edge k, evt is seen at edge k, and STATUS is set after edge k. o_irq is high after edge k+1, provided the enable bit is set.
- A W1C write that clears the last pending bit drops o_irq one cycle after the write handshake.

## Test plan
- Reset, then read all offsets 0x00..0x10: every rdata is 0, rresp 0, o_irq 0. Read 0x14: rdata 0, rresp 2'b10.
- Write ENABLE=0x1, then pulse i_cnt0_done for 1 cycle: STATUS=0x1, PENDING=0x1, EVT_CNT0=1, o_irq rises 2 cycles after the pulse. Write STATUS=0x1: o_irq falls and STATUS reads 0.
- Hold i_cnt1_done high for 10 cycles with ENABLE=0: EVT_CNT1=1, STATUS=0x2, o_irq stays 0. Write ENABLE=0x2: o_irq rises.
- Make a W1C write to STATUS bit0 handshake on the same edge as a cnt0 rising edge: STATUS bit0 remains 1. Make an EVT_CNT0 write coincide with an event: EVT_CNT0 reads 1.
- With EVT_CNT_BW_p=4, apply 20 rising edges on cnt0: EVT_CNT0 reads 0xF.
- AXI stress:
  - Present awvalid without wvalid for 5 cycles: no awready.
  - Hold bready low for 8 cycles: bvalid is held and a second write is stalled.
  - Hold rready low: rdata is stable.
  - Assert rst_n low during a pending bvalid: all outputs are 0 on the next cycle.
